// File: rtl/piso_bit_feeder.sv
// rtl/piso_bit_feeder.sv - WIDTH-bit parallel-in/serial-out feeder with a one-word hold buffer
// Build macro PISO_LSB_FIRST_EN selects LSB-first emission; default build emits MSB first.
module piso_bit_feeder #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);
    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
    localparam logic [7:0] GAP_INIT = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
`ifdef PISO_LSB_FIRST_EN
    localparam int OUT_IDX = 0;
`else
    localparam int OUT_IDX = WIDTH - 1;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [7:0]       gcnt_q, gcnt_d;
    logic [WIDTH-1:0] shreg_next;

`ifdef PISO_LSB_FIRST_EN
    assign shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
`else
    assign shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bcnt_d      = bcnt_q;
        gcnt_d      = gcnt_q;

        // Accept and hold->shift transfer are mutually exclusive: one needs empty, the other full.
        if (load_valid && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    bcnt_d      = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = shreg_next;
                bcnt_d  = bcnt_q + BW'(1);
                if (bcnt_q == LAST_IDX) begin
                    bcnt_d = '0;
                    if (GAP > 0) begin
                        gcnt_d  = GAP_INIT;
                        state_d = ST_GAP;
                    end else if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gcnt_q == 8'd0) begin
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                        bcnt_d      = '0;
                        state_d     = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bcnt_q      <= '0;
            gcnt_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bcnt_q      <= bcnt_d;
            gcnt_q      <= gcnt_d;
        end
    end

    assign load_ready = !hold_full_q;
    assign bit_valid  = (state_q == ST_SHIFT);
    assign dout       = bit_valid && shreg_q[OUT_IDX];
    assign last_bit   = bit_valid && (bcnt_q == LAST_IDX);
    assign busy       = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: tb/tb_piso_bit_feeder.sv
// tb/tb_piso_bit_feeder.sv - self-checking bench for piso_bit_feeder (GAP=0 and GAP=2 instances)
module tb_piso_bit_feeder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] d0_data = 8'h00;
    logic       d0_valid = 1'b0;
    logic       d0_ready, d0_dout, d0_bv, d0_last, d0_busy;

    logic [7:0] d2_data = 8'h00;
    logic       d2_valid = 1'b0;
    logic       d2_ready, d2_dout, d2_bv, d2_last, d2_busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    piso_bit_feeder #(.WIDTH(8), .GAP(0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .data_in(d0_data), .load_valid(d0_valid),
        .load_ready(d0_ready), .dout(d0_dout), .bit_valid(d0_bv),
        .last_bit(d0_last), .busy(d0_busy)
    );

    piso_bit_feeder #(.WIDTH(8), .GAP(2)) dut2 (
        .CLK(clk), .RST_N(rst_n), .data_in(d2_data), .load_valid(d2_valid),
        .load_ready(d2_ready), .dout(d2_dout), .bit_valid(d2_bv),
        .last_bit(d2_last), .busy(d2_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // i-th emitted bit of a word, straight from the configured bit order
    function automatic logic exp_bit(input logic [7:0] w, input int i);
`ifdef PISO_LSB_FIRST_EN
        return w[i];
`else
        return w[7-i];
`endif
    endfunction

    // Reference model for dut0: every accepted word appends its bits to one expected stream.
    logic exp_q[$];
    logic mon_en = 1'b0;
    int   bitpos = 0;
    int   run_len = 0;
    int   last_run = 0;

    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_bit(w, i));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (d0_bv) begin
                check("stream_has_expected_bit", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("stream_bit", d0_dout, exp_q.pop_front());
                check("stream_last_bit", d0_last, (bitpos % 8) == 7);
                bitpos++;
                run_len++;
            end else begin
                check("stream_idle_outputs", {d0_dout, d0_last}, 2'b00);
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    // Called at a negedge; greedily offers w to dut0, returns at the negedge after acceptance.
    task automatic send0(input logic [7:0] w);
        int t = 0;
        while (!d0_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("send0_ready_in_time", {31'd0, t < 100}, 32'd1);
        d0_valid = 1'b1;
        d0_data  = w;
        push_word(w);
        @(negedge clk);
        d0_valid = 1'b0;
        d0_data  = 8'($urandom);
    endtask

    task automatic restart_monitor();
        exp_q.delete();
        bitpos   = 0;
        run_len  = 0;
        last_run = 0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] msb_seq;
        logic [7:0] lsb_seq;
    } vec_t;

    vec_t tbl[5];
    logic [7:0] seq;
    logic [7:0] gap_words[2];
    logic       rec_bv[40];
    logic       rec_do[40];
    logic       rec_last[40];
    int         bad;
    int         idx;

    initial begin
        tbl[0] = '{8'hA0, 8'b1010_0000, 8'b0000_0101};
        tbl[1] = '{8'hFF, 8'b1111_1111, 8'b1111_1111};
        tbl[2] = '{8'h01, 8'b0000_0001, 8'b1000_0000};
        tbl[3] = '{8'h12, 8'b0001_0010, 8'b0100_1000};
        tbl[4] = '{8'h6B, 8'b0110_1011, 8'b1101_0110};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_dout", d0_dout, 1'b0);
        check("rst_bit_valid", d0_bv, 1'b0);
        check("rst_last_bit", d0_last, 1'b0);
        check("rst_busy", d0_busy, 1'b0);
        check("rst_load_ready", d0_ready, 1'b1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_release", {d0_dout, d0_bv, d0_busy}, 3'b000);

        // Single words, table driven: first bit two cycles after the accept edge
        for (int v = 0; v < 5; v++) begin
`ifdef PISO_LSB_FIRST_EN
            seq = tbl[v].lsb_seq;
`else
            seq = tbl[v].msb_seq;
`endif
            check("tbl_idle_before", d0_busy, 1'b0);
            d0_valid = 1'b1;
            d0_data  = tbl[v].data;
            @(negedge clk);
            d0_valid = 1'b0;
            check("tbl_ready_after_accept", d0_ready, 1'b0);
            check("tbl_busy_after_accept", d0_busy, 1'b1);
            check("tbl_no_bit_yet", {d0_bv, d0_dout}, 2'b00);
            @(negedge clk);
            check("tbl_ready_after_transfer", d0_ready, 1'b1);
            for (int i = 0; i < 8; i++) begin
                check("tbl_bit_valid", d0_bv, 1'b1);
                check("tbl_dout", d0_dout, seq[7-i]);
                check("tbl_last_bit", d0_last, i == 7);
                @(negedge clk);
            end
            check("tbl_end_outputs", {d0_bv, d0_dout, d0_last, d0_busy}, 4'b0000);
        end

        // Back-to-back words with GAP=0: one contiguous 16-bit run
        restart_monitor();
        mon_en = 1'b1;
        send0(8'hA5);
        send0(8'h5A);
        repeat (20) @(negedge clk);
        check("b2b_run_length", last_run, 16);
        check("b2b_all_bits_seen", exp_q.size(), 0);

        // Backpressure: valid held high with changing data
        restart_monitor();
        for (int k = 0; k < 40; k++) begin
            d0_valid = 1'b1;
            d0_data  = 8'($urandom);
            if (d0_ready) push_word(d0_data);
            @(negedge clk);
            if (k == 0) check("bp_ready_low_when_full", d0_ready, 1'b0);
        end
        d0_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("bp_all_bits_seen", exp_q.size(), 0);
        check("bp_idle_after_drain", d0_busy, 1'b0);

        // Randomized traffic against the stream model
        restart_monitor();
        for (int k = 0; k < 600; k++) begin
            d0_valid = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            if (k % 100 > 70) d0_valid = 1'b1;
            d0_data = 8'($urandom);
            if (d0_valid && d0_ready) push_word(d0_data);
            @(negedge clk);
        end
        d0_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("rand_all_bits_seen", exp_q.size(), 0);
        mon_en = 1'b0;

        // Reset mid-word with a second word held: output stops at once, nothing resumes
        send0(8'hFF);
        send0(8'hAA);
        @(negedge clk);
        check("midrst_shifting", {d0_bv, d0_busy}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_async_outputs", {d0_dout, d0_bv, d0_last, d0_busy}, 4'b0000);
        check("midrst_async_ready", d0_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d0_bv || d0_dout || d0_busy) bad++;
        end
        check("midrst_no_residual", bad, 0);
        exp_q.delete();

        // GAP=2 instance: two queued words separated by exactly two idle cycles
        gap_words[0] = 8'hC3;
        gap_words[1] = 8'h96;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            rec_bv[c]   = d2_bv;
            rec_do[c]   = d2_dout;
            rec_last[c] = d2_last;
            if (idx < 2 && d2_ready) begin
                d2_valid = 1'b1;
                d2_data  = gap_words[idx];
                idx++;
            end else begin
                d2_valid = 1'b0;
            end
            @(negedge clk);
        end
        for (int c = 0; c < 24; c++) begin
            if (c >= 2 && c <= 9) begin
                check("gap_w0_valid", rec_bv[c], 1'b1);
                check("gap_w0_dout", rec_do[c], exp_bit(gap_words[0], c - 2));
                check("gap_w0_last", rec_last[c], c == 9);
            end else if (c >= 12 && c <= 19) begin
                check("gap_w1_valid", rec_bv[c], 1'b1);
                check("gap_w1_dout", rec_do[c], exp_bit(gap_words[1], c - 12));
                check("gap_w1_last", rec_last[c], c == 19);
            end else begin
                check("gap_idle", {rec_bv[c], rec_do[c], rec_last[c]}, 3'b000);
            end
        end
        check("gap_idle_at_end", d2_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", checks, fails);
        $fatal(1);
    end

endmodule
